booth_mul_sched: RTL

BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

---
 rtl/booth_mul_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/booth_mul_sched.sv
// Two-requester unsigned multiplier sharing one iterative radix-4 Booth engine.
// Round-robin arbitration, fixed WIDTH/2+1 cycle latency, result held until taken.
module booth_mul_sched #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 r0_valid,
   output logic                 r0_ready,
   input  logic [WIDTH-1:0]     r0_x,
   input  logic [WIDTH-1:0]     r0_y,
   input  logic                 r1_valid,
   output logic                 r1_ready,
   input  logic [WIDTH-1:0]     r1_x,
   input  logic [WIDTH-1:0]     r1_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_result,
   output logic                 out_id,
   output logic                 busy
);

   localparam int unsigned NDIG = WIDTH / 2 + 1;
   localparam int unsigned AW   = 2 * WIDTH + 2;
   localparam int unsigned YW   = WIDTH + 3;
   localparam int unsigned CW   = $clog2(NDIG + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            ptr;
   logic            grant;
   logic            accept;
   logic            id;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   mcand;
   logic [AW-1:0]   pp;
   logic [YW-1:0]   ybuf;
   logic [WIDTH-1:0] sel_x;
   logic [WIDTH-1:0] sel_y;

   // Round robin: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      grant = r1_valid;
      if (r0_valid && r1_valid) begin
         grant = ptr;
      end
   end

   // Ready is combinational and suppressed while reset is asserted.
   always_comb begin
      accept   = (state == IDLE) && !reset && (r0_valid || r1_valid);
      r0_ready = accept && !grant;
      r1_ready = accept && grant;
      sel_x    = grant ? r1_x : r0_x;
      sel_y    = grant ? r1_y : r0_y;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt == DONE);
         busy      <= (state_nxt != IDLE);
      end
   end

   // Booth digit from the low triplet {y[2i+1], y[2i], y[2i-1]} of the shifting multiplier.
   always_comb begin
      case (ybuf[2:0])
         3'b001, 3'b010: pp = mcand;
         3'b011:         pp = mcand << 1;
         3'b100:         pp = -(mcand << 1);
         3'b101, 3'b110: pp = -mcand;
         default:        pp = '0;
      endcase
   end

   // Multiplicand shifts left and multiplier right by one digit per CALC edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr   <= 1'b0;
         id    <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         mcand <= '0;
         ybuf  <= '0;
      end else if (accept) begin
         ptr   <= ~grant;
         id    <= grant;
         cnt   <= CW'(NDIG);
         acc   <= '0;
         mcand <= AW'(sel_x);
         ybuf  <= {2'b00, sel_y, 1'b0};
      end else if (state == CALC) begin
         acc   <= acc + pp;
         mcand <= mcand << 2;
         ybuf  <= ybuf >> 2;
         cnt   <= cnt - CW'(1);
      end
   end

   assign out_result = acc[2*WIDTH-1:0];
   assign out_id     = id;

endmodule
